charge_slot_scheduler: RTL
==========================

// Module: charge_slot_scheduler
// PURPOSE
//  Shares MAX_ACTIVE charging power slots between NUM_PORTS phone ports.
//  Paid time is loaded per port from the payment/keypad front end.
//  The block queues the port, grants slots round-robin and counts its time down once per second.
//  Sits between payment logic and the per-port charge relays/display.
// PARAMETERS
//  NUM_PORTS   4         number of charging ports (port id width fixed at 2 bits)
//  MAX_ACTIVE  2         max ports charging at once
//  TICK_DIV    50000000  clk cycles per 1 s tick (50 MHz -> 1 Hz)
//  MAX_TIME    40        saturation limit for per-port time, seconds
//  TIME_W      6         width of time values
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  reset, asynchronous, active-high
//  load_valid   in   1                  add paid time to a port (always accepted)
//  load_port    in   2                  target port of load
//  load_time    in   TIME_W             seconds to add
//  cancel_valid in   1                  abort a port (user unplug)
//  cancel_port  in   2                  target port of cancel
//  charge_en    out  NUM_PORTS          registered; 1 = port relay on (state CHARGE)
//  waiting      out  NUM_PORTS          registered; 1 = port in state WAIT
//  port_time    out  NUM_PORTS*TIME_W   remaining seconds, port i at [i*TIME_W +: TIME_W]
//  tick         out  1                  one-cycle pulse per second
// BEHAVIOUR
//  Reset: all outputs 0, all ports IDLE, rr_ptr=0, tick counter=0; reset mid-operation aborts everything.
//  Tick: counter 0..TICK_DIV-1; tick=1 in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0; free-running.
//  Per-port FSM (IDLE/WAIT/CHARGE); next state and time are updated each cycle in priority order:
//   1 cancel on port -> IDLE, time=0; a same-cycle load to that port is dropped
//   2 load: new = sat(cur - dec + load_time), computed in TIME_W+1 bits, where sat caps at MAX_TIME
//     dec=1 if tick and port in CHARGE, else 0
//     IDLE + load_time>0 -> WAIT; IDLE + load_time==0 -> stays IDLE
//     WAIT/CHARGE keep state (top-up)
//   3 tick with no load: CHARGE ports decrement; a result of 0 -> IDLE, slot freed
//  Grant: each cycle, if active<MAX_ACTIVE (active = registered count of CHARGE ports), grant one port:
//   - the first WAIT port searching from rr_ptr upward, with wrap
//   - granted port WAIT->CHARGE next cycle; rr_ptr <= granted+1 mod NUM_PORTS
//   - at most one grant per cycle; no grant -> rr_ptr unchanged
//   - a port cancelled in the same cycle is not grantable
//  Latency: load at cycle t -> waiting=1 at t+1 -> charge_en=1 at t+2 (if a slot is free).
//   A slot freed by expiry/cancel at t is reusable by a grant at t+1 (charge_en at t+2).
//  A CHARGE port never decrements below 0; a WAIT port's time never decrements.
//  charge_en and waiting are never both 1 for a port; popcount(charge_en) <= MAX_ACTIVE always.
// TESTING  (bench uses TICK_DIV=4)
//  1 load port0 time 5 -> waiting[0] at t+1, charge_en[0] at t+2, deasserts after the 5th tick, port_time0=0
//  2 load ports 0,1,2,3 time 3 on consecutive cycles
//    -> ports 0,1 charge, 2,3 wait; port0 expires -> port2 granted; then port3
//  3 load port1 30, then top-up 30 -> port_time1=40 (saturated); top-up on a tick cycle while charging -> sat(t-1+x)
//  4 cancel port0 while charging, with same-cycle load port0 -> port0 IDLE, time 0; waiting port granted next cycle
//  5 all 4 ports waiting, slots cycling -> grants follow rr_ptr order 0,1,2,3,0; no port starved
//  6 assert rst_n mid-charge -> all outputs 0 asynchronously; after release, load port2 works normally

Source files
------------

// File: rtl/charge_slot_scheduler.sv
// Charge slot scheduler: shares MAX_ACTIVE charging slots among NUM_PORTS
// phone ports. Paid time is queued per port, slots are granted round-robin,
// and charging ports count their time down once per second.
module charge_slot_scheduler #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned MAX_ACTIVE = 2,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned MAX_TIME   = 40,
  parameter int unsigned TIME_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  input  logic [1:0]                  load_port,
  input  logic [TIME_W-1:0]           load_time,
  input  logic                        cancel_valid,
  input  logic [1:0]                  cancel_port,
  output logic [NUM_PORTS-1:0]        charge_en,
  output logic [NUM_PORTS-1:0]        waiting,
  output logic [NUM_PORTS*TIME_W-1:0] port_time,
  output logic                        tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACT_W = $clog2(NUM_PORTS + 1);
  localparam logic [TIME_W:0] MAX_T = (TIME_W+1)'(MAX_TIME);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHARGE
  } port_state_t;

  port_state_t       state    [NUM_PORTS];
  port_state_t       state_nx [NUM_PORTS];
  logic [TIME_W-1:0] ptime    [NUM_PORTS];
  logic [TIME_W-1:0] ptime_nx [NUM_PORTS];

  logic [CNT_W-1:0]  tick_cnt;
  logic [1:0]        rr_ptr;
  logic [1:0]        rr_nx;
  logic [ACT_W-1:0]  active;
  logic              grant_hit;
  logic [1:0]        grant_idx;
  logic [2:0]        scan;
  logic [2:0]        rr_sum;
  logic [TIME_W:0]   sum;

  // Once-per-second strobe decoded from the free-running divider
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running second divider
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Number of slots currently held, from registered port states
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (state[i] == CHARGE) active = active + ACT_W'(1);
    end
  end

  // Round-robin pick of the first grantable WAIT port from rr_ptr upward
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    scan      = '0;
    rr_sum    = '0;
    if (active < ACT_W'(MAX_ACTIVE)) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        scan = {1'b0, rr_ptr} + 3'(k);
        if (scan >= 3'(NUM_PORTS)) scan = scan - 3'(NUM_PORTS);
        if (!grant_hit && state[scan[1:0]] == WAIT &&
            !(cancel_valid && cancel_port == scan[1:0])) begin
          grant_hit = 1'b1;
          grant_idx = scan[1:0];
        end
      end
    end
    rr_nx = rr_ptr;
    if (grant_hit) begin
      rr_sum = {1'b0, grant_idx} + 3'd1;
      if (rr_sum >= 3'(NUM_PORTS)) rr_sum = rr_sum - 3'(NUM_PORTS);
      rr_nx = rr_sum[1:0];
    end
  end

  // Per-port next state/time: cancel beats load beats tick; a grant then
  // promotes the chosen WAIT port (a top-up in the same cycle keeps its time)
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      state_nx[i] = state[i];
      ptime_nx[i] = ptime[i];
      if (cancel_valid && cancel_port == 2'(i)) begin
        state_nx[i] = IDLE;
        ptime_nx[i] = '0;
      end else if (load_valid && load_port == 2'(i)) begin
        sum = {1'b0, ptime[i]} + {1'b0, load_time};
        if (tick && state[i] == CHARGE && sum != '0) sum = sum - (TIME_W+1)'(1);
        if (sum > MAX_T) sum = MAX_T;
        ptime_nx[i] = sum[TIME_W-1:0];
        if (state[i] == IDLE && load_time != '0) state_nx[i] = WAIT;
      end else if (tick && state[i] == CHARGE) begin
        if (ptime[i] <= TIME_W'(1)) begin
          state_nx[i] = IDLE;
          ptime_nx[i] = '0;
        end else begin
          ptime_nx[i] = ptime[i] - TIME_W'(1);
        end
      end
      if (grant_hit && grant_idx == 2'(i)) state_nx[i] = CHARGE;
    end
  end

  // Port FSMs, round-robin pointer and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_ptr    <= '0;
      charge_en <= '0;
      waiting   <= '0;
      port_time <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state[i] <= IDLE;
        ptime[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_nx;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state[i]                         <= state_nx[i];
        ptime[i]                         <= ptime_nx[i];
        charge_en[i]                     <= (state_nx[i] == CHARGE);
        waiting[i]                       <= (state_nx[i] == WAIT);
        port_time[i*TIME_W +: TIME_W]    <= ptime_nx[i];
      end
    end
  end

endmodule
